// File: rtl/music_pkg.sv
// Shared definitions for the note recorder/player: FSM state encoding and
// default memory depth.
package music_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        PLAY    = 2'd3
    } state_t;

    localparam int MAX_NOTES_DEFAULT = 16;
    localparam int COUNT_W           = 5;
    localparam int ADDR_W            = 4;

endpackage

// File: rtl/note_sequencer_beat_timer.sv
// Beat timer: counts 0..NOTE_CYCLES-1 while enabled and flags the last
// cycle of each beat with a one-cycle terminal-count strobe.
module beat_timer #(
    parameter int NOTE_CYCLES = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(NOTE_CYCLES - 1);

    logic [W-1:0] count;
    logic         at_last;

    assign at_last = (count == LAST);
    assign tc      = en & at_last;

    // Explicit wrap at LAST keeps non-power-of-two beat lengths correct.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback sequencer: key edge detection, the IDLE/LOAD/RELEASE/PLAY
// controller and registered datapath strobes.
module note_sequencer
    import music_pkg::*;
#(
    parameter int NOTE_CYCLES = 25000000,
    parameter int MAX_NOTES   = MAX_NOTES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rec_key,
    input  logic               play_key,
    input  logic               stop_key,
    output logic               ld_note,
    output logic               ld_play,
    output logic [ADDR_W-1:0]  note_counter,
    output logic               next_note_en,
    output logic               display_note,
    output logic [COUNT_W-1:0] note_count,
    output logic               busy
);

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_NOTES);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + COUNT_W'(1);
    endfunction

    state_t state, state_nx;

    logic rec_q, play_q, stop_q;
    logic rec_edge, play_edge, stop_edge;
    logic load_min, load_min_nx;
    logic [COUNT_W-1:0] note_count_nx;
    logic [ADDR_W-1:0]  note_counter_nx;
    logic next_note_nx, display_nx;
    logic tc, timer_clr, timer_en, last_note;

    assign rec_edge  = rec_key  & ~rec_q;
    assign play_edge = play_key & ~play_q;
    assign stop_edge = stop_key & ~stop_q;

    assign last_note = ({1'b0, note_counter} == (note_count - COUNT_W'(1)));
    assign timer_en  = (state == PLAY);
    assign timer_clr = (state != PLAY) | tc;

    beat_timer #(
        .NOTE_CYCLES(NOTE_CYCLES)
    ) u_beat_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr),
        .en   (timer_en),
        .tc   (tc)
    );

    always_comb begin
        state_nx        = state;
        load_min_nx     = load_min;
        note_count_nx   = note_count;
        note_counter_nx = note_counter;
        next_note_nx    = 1'b0;
        display_nx      = 1'b0;

        unique case (state)
            IDLE: begin
                if (stop_edge) begin
                    note_count_nx = '0;
                end else if (play_edge) begin
                    if (note_count != '0) begin
                        state_nx     = PLAY;
                        next_note_nx = 1'b1;
                    end
                end else if (rec_edge && (note_count < MAX_CNT)) begin
                    state_nx    = LOAD;
                    load_min_nx = 1'b0;
                end
            end
            LOAD: begin
                // load_min marks that the 2-cycle minimum store pulse has elapsed.
                load_min_nx = 1'b1;
                if (stop_edge) begin
                    state_nx = IDLE;
                end else if (!rec_key && load_min) begin
                    state_nx      = RELEASE;
                    display_nx    = 1'b1;
                    note_count_nx = sat_inc(note_count);
                end
            end
            RELEASE: begin
                state_nx = IDLE;
            end
            PLAY: begin
                if (stop_edge) begin
                    state_nx = IDLE;
                end else if (tc) begin
                    if (last_note) begin
                        state_nx = IDLE;
                    end else begin
                        note_counter_nx = note_counter + ADDR_W'(1);
                        next_note_nx    = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx != PLAY) begin
            note_counter_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rec_q        <= 1'b0;
            play_q       <= 1'b0;
            stop_q       <= 1'b0;
            load_min     <= 1'b0;
            ld_note      <= 1'b0;
            ld_play      <= 1'b0;
            note_counter <= '0;
            next_note_en <= 1'b0;
            display_note <= 1'b0;
            note_count   <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            rec_q        <= rec_key;
            play_q       <= play_key;
            stop_q       <= stop_key;
            load_min     <= load_min_nx;
            ld_note      <= (state_nx == LOAD);
            ld_play      <= (state_nx == PLAY);
            note_counter <= note_counter_nx;
            next_note_en <= next_note_nx;
            display_note <= display_nx;
            note_count   <= note_count_nx;
            busy         <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with a 4-cycle beat: directed record,
// playback, full-memory, abort, priority and mid-play reset scenarios.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rec_key = 1'b0;
    logic       play_key = 1'b0;
    logic       stop_key = 1'b0;
    logic       ld_note, ld_play, next_note_en, display_note, busy;
    logic [3:0] note_counter;
    logic [4:0] note_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;
    int disp_q[$];
    int note_q[$];

    note_sequencer #(.NOTE_CYCLES(4), .MAX_NOTES(16)) dut (
        .clk(clk), .reset(reset), .rec_key(rec_key), .play_key(play_key),
        .stop_key(stop_key), .ld_note(ld_note), .ld_play(ld_play),
        .note_counter(note_counter), .next_note_en(next_note_en),
        .display_note(display_note), .note_count(note_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (reset) begin
            if (display_note) begin
                if (disp_q.size() == 0) check("display_unexpected", 1, 0);
                else check("display_note_count", int'(note_count), disp_q.pop_front());
            end
            if (next_note_en) begin
                if (note_q.size() == 0) check("next_note_unexpected", 1, 0);
                else check("next_note_counter", int'(note_counter), note_q.pop_front());
            end
            if (ld_note && ld_play) check("ld_exclusive", 1, 0);
        end
    end

    task automatic record(input int hold);
        int n = 0;
        int exp_ld = (hold < 2) ? 2 : hold;
        exp_count = (exp_count < 16) ? exp_count + 1 : 16;
        disp_q.push_back(exp_count);
        rec_key = 1'b1;
        repeat (hold) begin
            tick();
            if (ld_note) n++;
        end
        rec_key = 1'b0;
        for (int i = 0; i < 10 && busy; i++) begin
            tick();
            if (ld_note) n++;
        end
        check("record_done_busy", int'(busy), 0);
        check("ld_note_len", n, exp_ld);
        check("note_count_after_rec", int'(note_count), exp_count);
    endtask

    task automatic play_edge();
        play_key = 1'b1;
        tick();
        play_key = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_note"}, int'(ld_note), 0);
        check({tag, "_ld_play"}, int'(ld_play), 0);
        check({tag, "_note_counter"}, int'(note_counter), 0);
        check({tag, "_next_note_en"}, int'(next_note_en), 0);
        check({tag, "_display_note"}, int'(display_note), 0);
        check({tag, "_note_count"}, int'(note_count), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;

        // Reset state
        reset = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Record one note with a 5-cycle key press, then two more
        record(5);
        record(1);
        record(3);

        // Play three notes, each address held 4 cycles
        note_q.push_back(0); note_q.push_back(1); note_q.push_back(2);
        play_edge();
        n = 0;
        for (int i = 0; i < 30 && ld_play; i++) begin
            check("play_addr", int'(note_counter), n / 4);
            n++;
            tick();
        end
        check("play_len", n, 12);
        check("play_end_busy", int'(busy), 0);
        check("play_end_addr", int'(note_counter), 0);

        // Abort playback at note 1
        note_q.push_back(0); note_q.push_back(1);
        play_edge();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (note_counter == 4'd1) seen = 1;
            else tick();
        end
        check("abort_reached_note1", seen, 1);
        stop_key = 1'b1;
        tick();
        stop_key = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_ld_play", int'(ld_play), 0);
        check("abort_note_count", int'(note_count), 3);
        tick();

        // Stop in IDLE clears the memory count
        stop_key = 1'b1;
        tick();
        stop_key = 1'b0;
        check("stop_idle_clear", int'(note_count), 0);
        exp_count = 0;
        tick();

        // Aborted LOAD does not commit a note
        rec_key = 1'b1;
        tick();
        check("abort_load_ld_note", int'(ld_note), 1);
        stop_key = 1'b1;
        tick();
        check("abort_load_ld_note_off", int'(ld_note), 0);
        check("abort_load_busy", int'(busy), 0);
        rec_key = 1'b0;
        stop_key = 1'b0;
        tick(); tick();
        check("abort_load_count", int'(note_count), 0);

        // Fill all 16 slots, then a further record request is ignored
        for (int k = 0; k < 16; k++) record(1);
        rec_key = 1'b1;
        n = 0;
        repeat (5) begin
            tick();
            if (ld_note || busy) n++;
        end
        rec_key = 1'b0;
        check("full_rec_ignored", n, 0);
        check("full_count", int'(note_count), 16);
        tick();

        // Empty memory: play request is ignored
        stop_key = 1'b1;
        tick();
        stop_key = 1'b0;
        exp_count = 0;
        check("full_clear", int'(note_count), 0);
        play_key = 1'b1;
        n = 0;
        repeat (4) begin
            tick();
            if (busy) n++;
        end
        play_key = 1'b0;
        check("empty_play_busy", n, 0);
        tick();

        // Coincident rec+play with two notes: play wins, then reset mid-PLAY
        record(2);
        record(2);
        note_q.push_back(0);
        rec_key = 1'b1;
        play_key = 1'b1;
        tick();
        check("coinc_ld_play", int'(ld_play), 1);
        check("coinc_ld_note", int'(ld_note), 0);
        check("coinc_busy", int'(busy), 1);
        tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("midplay_reset");
        rec_key = 1'b0;
        play_key = 1'b0;
        reset = 1'b1;
        tick(); tick();
        check("post_reset_busy", int'(busy), 0);

        check("disp_q_empty", disp_q.size(), 0);
        check("note_q_empty", note_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
